// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared types and helpers for the multi-channel coefficient MAC engine.
//   state_t  : sequencer states
//   sat_add  : signed add with clamp to a w-bit signed range, reports clamping
// ---------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MAC   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Operands are carried sign-extended in this width so one function
    // serves any accumulator width below it.
    localparam int SAT_MAX_W = 64;

    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input  logic signed [SAT_MAX_W-1:0] a,
        input  logic signed [SAT_MAX_W-1:0] b,
        input  int                          w,
        output logic                        clamped
    );
        logic signed [SAT_MAX_W-1:0] sum;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sum     = a + b;
        hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (w - 1));
        clamped = 1'b0;
        if (sum > hi) begin
            sum     = hi;
            clamped = 1'b1;
        end else if (sum < lo) begin
            sum     = lo;
            clamped = 1'b1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// ---------------------------------------------------------------------------
// dsp_mac_lane
// One channel: signed sample x coefficient, saturating accumulate, sticky
// overflow flag.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           global enable, low freezes the lane
//   i_clear        run start: zero accumulator and overflow flag
//   i_acc_en       sample accepted this cycle: accumulate product
//   i_din          signed sample (DATA_W)
//   i_coef         signed coefficient (COEF_W)
//   o_acc          accumulator (ACC_W, signed)
//   o_ovf          set when any accumulate clamped since last clear
// ---------------------------------------------------------------------------
module dsp_mac_lane
    import dsp_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int COEF_W = 14,
    parameter int ACC_W  = 26
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clear,
    input  logic              i_acc_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic [COEF_W-1:0] i_coef,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_ovf
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0]      w_din_x;
    logic signed [PROD_W-1:0]      w_coef_x;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [SAT_MAX_W-1:0]   w_prod_x;
    logic signed [SAT_MAX_W-1:0]   w_acc_x;
    logic [ACC_W-1:0]              w_sum;
    logic [SAT_MAX_W-ACC_W-1:0]    w_sum_hi_unused;
    logic                          w_clamp;

    logic [ACC_W-1:0]              r_acc;
    logic                          r_ovf;

    always_comb begin
        w_din_x  = {{(PROD_W-DATA_W){i_din[DATA_W-1]}}, i_din};
        w_coef_x = {{(PROD_W-COEF_W){i_coef[COEF_W-1]}}, i_coef};
        // Both operands sign-extended to the product width, so the low
        // PROD_W bits hold the exact signed product.
        w_prod   = w_din_x * w_coef_x;
        w_prod_x = {{(SAT_MAX_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        w_acc_x  = {{(SAT_MAX_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
        w_clamp  = 1'b0;
        // Result is already clamped into ACC_W, upper bits are pure sign.
        {w_sum_hi_unused, w_sum} = sat_add(w_acc_x, w_prod_x, ACC_W, w_clamp);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            if (i_clear) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (i_acc_en) begin
                r_acc <= w_sum;
                if (w_clamp) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// dsp_mac_seq
// Multi-channel coefficient MAC engine. A run streams i_taps samples per
// channel; each sample is multiplied by a coefficient read from external RAM
// and accumulated with saturation. One result word per run.
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_en             global enable, low freezes everything
//   i_start, i_taps  start a run of i_taps (1..2**ADDR_W) taps from IDLE
//   i_din            NUM_CH signed samples, i_din_valid qualifies them
//   o_din_ready      engine takes i_din this cycle
//   o_memaddr        coefficient RAM address, i_memdout one cycle later
//   o_dout           NUM_CH results, o_dout_valid pulses on update
//   o_busy           run in progress
//   o_ovf            per-channel sticky saturation flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start with nonzero tap count
// ST_FETCH | coefficient RAM read in flight for current tap
// ST_MAC   | coefficient valid, waiting for a sample to accept
// ST_DONE  | register accumulators to o_dout, pulse o_dout_valid
// ---------------------------------------------------------------------------
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter logic RST_VAL = 1'b0,
    parameter int   DATA_W  = 12,
    parameter int   COEF_W  = 14,
    parameter int   ADDR_W  = 6,
    parameter int   ACC_W   = 26,
    parameter int   NUM_CH  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_start,
    input  logic [ADDR_W:0]          i_taps,
    input  logic [NUM_CH*DATA_W-1:0] i_din,
    input  logic                     i_din_valid,
    output logic                     o_din_ready,
    output logic [ADDR_W-1:0]        o_memaddr,
    input  logic [COEF_W-1:0]        i_memdout,
    output logic [NUM_CH*ACC_W-1:0]  o_dout,
    output logic                     o_dout_valid,
    output logic                     o_busy,
    output logic [NUM_CH-1:0]        o_ovf
);
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    state_t                    r_state;
    logic [ADDR_W:0]           r_taps;
    logic [ADDR_W:0]           r_idx;
    logic [ADDR_W-1:0]         r_memaddr;
    logic [NUM_CH*ACC_W-1:0]   r_dout;
    logic                      r_dout_valid;

    logic                      w_go;
    logic                      w_accept;
    logic                      w_last;
    logic [ADDR_W:0]           w_idx_nxt;
    logic [NUM_CH*ACC_W-1:0]   w_acc;

    assign w_go        = (r_state == ST_IDLE) & i_en & i_start & (i_taps != '0);
    assign o_din_ready = (r_state == ST_MAC) & i_en;
    assign w_accept    = o_din_ready & i_din_valid;
    assign w_last      = (r_idx == (r_taps - IDX_ONE));
    assign w_idx_nxt   = r_idx + IDX_ONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_taps       <= '0;
            r_idx        <= '0;
            r_memaddr    <= '0;
            r_dout       <= {(NUM_CH*ACC_W){RST_VAL}};
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (i_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_go) begin
                            r_taps    <= i_taps;
                            r_idx     <= '0;
                            r_memaddr <= '0;
                            r_state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state <= ST_MAC;
                    end
                    ST_MAC: begin
                        if (w_accept) begin
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end else begin
                                // idx+1 <= taps-1 < 2**ADDR_W, so the
                                // truncation never drops a set bit.
                                r_idx     <= w_idx_nxt;
                                r_memaddr <= w_idx_nxt[ADDR_W-1:0];
                                r_state   <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_dout       <= w_acc;
                        r_dout_valid <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        dsp_mac_lane #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_en     (i_en),
            .i_clear  (w_go),
            .i_acc_en (w_accept),
            .i_din    (i_din[c*DATA_W +: DATA_W]),
            .i_coef   (i_memdout),
            .o_acc    (w_acc[c*ACC_W +: ACC_W]),
            .o_ovf    (o_ovf[c])
        );
    end

    assign o_memaddr    = r_memaddr;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dsp_mac_seq.sv
module tb_dsp_mac_seq;
    localparam int DATA_W = 12;
    localparam int COEF_W = 14;
    localparam int ADDR_W = 6;
    localparam int ACC_W  = 26;
    localparam int NUM_CH = 2;
    localparam int NTAP   = 1 << ADDR_W;

    logic                     i_clk;
    logic                     i_rst;
    logic                     i_en;
    logic                     i_start;
    logic [ADDR_W:0]          i_taps;
    logic [NUM_CH*DATA_W-1:0] i_din;
    logic                     i_din_valid;
    logic                     o_din_ready;
    logic [ADDR_W-1:0]        o_memaddr;
    logic [COEF_W-1:0]        i_memdout;
    logic [NUM_CH*ACC_W-1:0]  o_dout;
    logic                     o_dout_valid;
    logic                     o_busy;
    logic [NUM_CH-1:0]        o_ovf;

    dsp_mac_seq #(
        .RST_VAL (1'b0),
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .ADDR_W  (ADDR_W),
        .ACC_W   (ACC_W),
        .NUM_CH  (NUM_CH)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_start      (i_start),
        .i_taps       (i_taps),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .o_din_ready  (o_din_ready),
        .o_memaddr    (o_memaddr),
        .i_memdout    (i_memdout),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .o_busy       (o_busy),
        .o_ovf        (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic signed [COEF_W-1:0] coef_mem [NTAP];
    logic signed [DATA_W-1:0] s0 [NTAP];
    logic signed [DATA_W-1:0] s1 [NTAP];

    // synchronous-read coefficient RAM
    always @(posedge i_clk) i_memdout <= coef_mem[o_memaddr];

    typedef struct {
        longint     e0;
        longint     e1;
        logic [1:0] ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic exp_t model(input int n);
        exp_t   r;
        longint hi;
        longint lo;
        hi   = (64'sd1 <<< (ACC_W - 1)) - 1;
        lo   = -(64'sd1 <<< (ACC_W - 1));
        r.e0 = 0;
        r.e1 = 0;
        r.ov = 2'b00;
        for (int i = 0; i < n; i++) begin
            r.e0 = r.e0 + longint'(s0[i]) * longint'(coef_mem[i]);
            r.e1 = r.e1 + longint'(s1[i]) * longint'(coef_mem[i]);
            if (r.e0 > hi) begin r.e0 = hi; r.ov[0] = 1'b1; end
            if (r.e0 < lo) begin r.e0 = lo; r.ov[0] = 1'b1; end
            if (r.e1 > hi) begin r.e1 = hi; r.ov[1] = 1'b1; end
            if (r.e1 < lo) begin r.e1 = lo; r.ov[1] = 1'b1; end
        end
        return r;
    endfunction

    // scoreboard consumer
    always @(negedge i_clk) begin
        if (o_dout_valid) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_dv", 64'd1, 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_val("dout_ch0", longint'($signed(o_dout[0*ACC_W +: ACC_W])), sb_e.e0);
                check_val("dout_ch1", longint'($signed(o_dout[1*ACC_W +: ACC_W])), sb_e.e1);
                check_val("ovf", 64'(o_ovf), 64'(sb_e.ov));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) check_val("idle_timeout", 64'(o_busy), 64'd0);
    endtask

    task automatic start_run(input int n);
        wait_idle();
        @(negedge i_clk);
        i_taps  = (ADDR_W+1)'(n);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check_val("busy_after_start", 64'(o_busy), 64'd1);
    endtask

    // Feeds samples until ntaps (or stop_at, if nonzero) have been accepted.
    task automatic drive(input int ntaps, input bit rnd, input bit do_en,
                         input bit do_start, input int stop_at);
        int k    = 0;
        int cyc  = 0;
        int stop = (stop_at > 0) ? stop_at : ntaps;
        while (k < stop && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            i_start = 1'b0;
            i_en    = !(do_en && cyc >= 6 && cyc < 11);
            if (do_start && cyc == 3) begin
                i_start = 1'b1;
                i_taps  = (ADDR_W+1)'(5);
            end
            i_din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_din       = {s1[k], s0[k]};
            #1;
            if (!i_en) begin
                check_val("busy_hold", 64'(o_busy), 64'd1);
                check_val("ready_off", 64'(o_din_ready), 64'd0);
            end
            if (o_din_ready && i_din_valid) begin
                check_val("addr", 64'(o_memaddr), 64'(k));
                k++;
            end
        end
        if (k < stop) check_val("drive_timeout", 64'(k), 64'(stop));
        @(negedge i_clk);
        i_din_valid = 1'b0;
        i_en        = 1'b1;
        i_start     = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < NTAP; i++) begin
            coef_mem[i] = '0;
            s0[i]       = '0;
            s1[i]       = '0;
        end
        coef_mem[0] = 14'sd1; coef_mem[1] = 14'sd2; coef_mem[2] = 14'sd3; coef_mem[3] = 14'sd4;
        s0[0] = 12'sd1; s0[1] = 12'sd1; s0[2] = 12'sd1; s0[3] = 12'sd1;
        s1[0] = 12'sd2; s1[1] = 12'sd0; s1[2] = -12'sd1; s1[3] = 12'sd5;
    endtask

    initial begin
        exp_t e;
        i_rst = 1'b1; i_en = 1'b1; i_start = 1'b0; i_taps = '0;
        i_din = '0; i_din_valid = 1'b0;
        load_basic();
        repeat (3) @(negedge i_clk);
        check_val("rst_dout", 64'(o_dout), 64'd0);
        check_val("rst_dv", 64'(o_dout_valid), 64'd0);
        check_val("rst_ready", 64'(o_din_ready), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_addr", 64'(o_memaddr), 64'd0);
        check_val("rst_ovf", 64'(o_ovf), 64'd0);
        i_rst = 1'b0;

        // basic 4-tap run
        e = model(4);
        check_val("model_t1_ch0", 64'(e.e0), 64'd10);
        check_val("model_t1_ch1", 64'(e.e1), 64'd19);
        start_run(4); sb_q.push_back(e); drive(4, 0, 0, 0, 0); wait_idle();

        // random valid with enable dropped mid-run
        start_run(4); sb_q.push_back(model(4)); drive(4, 1, 1, 0, 0); wait_idle();

        // taps == 0 is ignored
        @(negedge i_clk);
        i_taps = '0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check_val("taps0_busy", 64'(o_busy), 64'd0);
        repeat (3) @(negedge i_clk);
        check_val("taps0_busy2", 64'(o_busy), 64'd0);

        // start during a run is ignored
        start_run(4); sb_q.push_back(model(4)); drive(4, 0, 0, 1, 0); wait_idle();

        // reset after tap 2 of 4
        start_run(4); drive(4, 0, 0, 0, 2);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_val("abort_busy", 64'(o_busy), 64'd0);
        check_val("abort_dout", 64'(o_dout), 64'd0);
        check_val("abort_ovf", 64'(o_ovf), 64'd0);
        check_val("abort_addr", 64'(o_memaddr), 64'd0);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        start_run(4); sb_q.push_back(model(4)); drive(4, 0, 0, 0, 0); wait_idle();

        // saturation, positive on ch0 and negative on ch1, full 64 taps
        for (int i = 0; i < NTAP; i++) begin
            coef_mem[i] = 14'sd8191;
            s0[i]       = 12'sd2047;
            s1[i]       = -12'sd2048;
        end
        e = model(NTAP);
        check_val("model_sat_pos", 64'(e.e0), 64'((64'sd1 <<< 25) - 1));
        check_val("model_sat_neg", 64'(e.e1), 64'(-(64'sd1 <<< 25)));
        start_run(NTAP); sb_q.push_back(e); drive(NTAP, 0, 0, 0, 0); wait_idle();

        // address sweep with distinct coefficients, ovf cleared by new start
        for (int i = 0; i < NTAP; i++) begin
            coef_mem[i] = COEF_W'(i + 1);
            s0[i]       = 12'sd1;
            s1[i]       = DATA_W'(i);
        end
        e = model(NTAP);
        check_val("model_sweep_ch0", 64'(e.e0), 64'd2080);
        check_val("model_sweep_ch1", 64'(e.e1), 64'd87360);
        start_run(NTAP); sb_q.push_back(e); drive(NTAP, 1, 0, 0, 0); wait_idle();

        repeat (5) @(negedge i_clk);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
